// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the serializer front end of the 1011 detector.
package bit_serializer_pkg;

    // One-bit serializer state encoding.
    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    // Default parallel word width.
    localparam int SER_DEFAULT_WIDTH = 8;

endpackage : bit_serializer_pkg

// File: rtl/bit_serializer_if.sv
// Parallel load handshake between a word producer and the serializer.
interface bit_serializer_if
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = SER_DEFAULT_WIDTH
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready
    );
endinterface : bit_serializer_if

// File: rtl/bit_serializer_mod_n_counter.sv
// Modulo-N up-counter with synchronous clear and terminal-count flag.
module mod_n_counter
    import bit_serializer_pkg::*;
#(
    parameter int N  = SER_DEFAULT_WIDTH,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          terminal
);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise advance and wrap at N-1.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign terminal = (count_q == LAST);
endmodule : mod_n_counter

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one word bit per clock, zero-gap back-to-back.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = SER_DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    bit_serializer_if.slave         load_if,
    output logic                    sequence_out,
    output logic                    bit_valid,
    output logic                    word_done,
    output logic                    busy
);
    localparam int CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

    ser_state_e       state_q;
    ser_state_e       state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CW-1:0]    count;
    logic             terminal;
    logic             in_shift;
    logic             accept;
    logic             load_ready;

    assign in_shift = (state_q == SER_SHIFT);
    // Ready is gated by reset so nothing is offered while reset is held.
    assign load_ready = reset & (~in_shift | terminal);
    assign accept     = load_if.load_valid & load_ready;
    assign load_if.load_ready = load_ready;

    mod_n_counter #(
        .N  (WIDTH),
        .CW (CW)
    ) u_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (accept),
        .enable   (in_shift),
        .count    (count),
        .terminal (terminal)
    );

    // Next state: accept enters/stays SHIFT; last bit without accept returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SER_IDLE: begin
                if (accept) state_d = SER_SHIFT;
            end
            SER_SHIFT: begin
                if (accept)        state_d = SER_SHIFT;
                else if (terminal) state_d = SER_IDLE;
            end
            default: state_d = SER_IDLE;
        endcase
    end

    // Next shift register: load on accept, else move toward the output end with zero fill.
    always_comb begin
        shift_d = shift_q;
        if (accept) begin
            shift_d = load_if.data_in;
        end else if (in_shift) begin
            if (MSB_FIRST != 0) shift_d = shift_q << 1;
            else                shift_d = shift_q >> 1;
        end
    end

    // State and shift register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= SER_IDLE;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end

    // Serial outputs: quiet line outside SHIFT.
    always_comb begin
        sequence_out = 1'b0;
        if (in_shift) sequence_out = shift_q[OUT_IDX];
        bit_valid = in_shift;
        busy      = in_shift;
        word_done = in_shift & terminal;
    end

    logic unused_count;
    assign unused_count = ^count;
endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Randomized scoreboard bench for bit_serializer (MSB-first and LSB-first instances).
module tb_bit_serializer;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         lv    = 1'b0;
    logic [W-1:0] din   = '0;

    logic seq_m, bv_m, wd_m, busy_m;
    logic seq_l, bv_l, wd_l, busy_l;

    int vectors     = 0;
    int miscompares = 0;

    logic q_m[$];
    logic q_l[$];

    always #5 clock = ~clock;

    bit_serializer_if #(.WIDTH(W)) ifm ();
    bit_serializer_if #(.WIDTH(W)) ifl ();

    assign ifm.load_valid = lv;
    assign ifm.data_in    = din;
    assign ifl.load_valid = lv;
    assign ifl.data_in    = din;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clock        (clock),
        .reset        (reset),
        .load_if      (ifm.slave),
        .sequence_out (seq_m),
        .bit_valid    (bv_m),
        .word_done    (wd_m),
        .busy         (busy_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clock        (clock),
        .reset        (reset),
        .load_if      (ifl.slave),
        .sequence_out (seq_l),
        .bit_valid    (bv_l),
        .word_done    (wd_l),
        .busy         (busy_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare one DUT's outputs against the pending-bit queue of its word stream.
    task automatic check_dut(input string tag, input logic seq, input logic bv,
                             input logic wd, input logic bs, input logic lr,
                             input int qsize, input logic head);
        logic exp_seq;
        exp_seq = (qsize > 0) ? head : 1'b0;
        chk({tag, ".bit_valid"},    32'(bv),  32'(qsize > 0));
        chk({tag, ".busy"},         32'(bs),  32'(qsize > 0));
        chk({tag, ".sequence_out"}, 32'(seq), 32'(exp_seq));
        chk({tag, ".word_done"},    32'(wd),  32'(qsize == 1));
        chk({tag, ".load_ready"},   32'(lr),  32'(reset && (qsize <= 1)));
    endtask

    // Monitor: one bit leaves each queue per cycle where the model expects one.
    initial begin
        forever begin
            @(negedge clock);
            check_dut("msb", seq_m, bv_m, wd_m, busy_m, ifm.load_ready,
                      q_m.size(), (q_m.size() > 0) ? q_m[0] : 1'b0);
            check_dut("lsb", seq_l, bv_l, wd_l, busy_l, ifl.load_ready,
                      q_l.size(), (q_l.size() > 0) ? q_l[0] : 1'b0);
            if (q_m.size() > 0) void'(q_m.pop_front());
            if (q_l.size() > 0) void'(q_l.pop_front());
        end
    end

    // Reference: a word is exactly W bits, in transmission order for each DUT.
    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) q_m.push_back(w[i]);
        for (int i = 0; i < W; i++)      q_l.push_back(w[i]);
    endtask

    task automatic idle(input int n);
        lv = 1'b0;
        repeat (n) begin
            din = W'($urandom);
            @(posedge clock);
            #1;
        end
    endtask

    // Present a word and hold it until accepted; valid stays high on return.
    task automatic send(input logic [W-1:0] w);
        logic acc;
        int   cycles;
        lv     = 1'b1;
        din    = w;
        cycles = 0;
        forever begin
            @(negedge clock);
            acc = lv && ifm.load_ready;
            @(posedge clock);
            if (acc) push_word(w);
            #1;
            if (acc) break;
            cycles++;
            if (cycles > 64) begin
                chk("accept_timeout", 32'(cycles), 32'(0));
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        lv    = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        idle(10);

        send(8'hB0);
        idle(12);

        send(8'hB0);
        send(8'h0B);
        idle(10);

        send(8'hB0);
        idle(2);
        send(8'hFF);
        idle(10);

        // Reset during the 4th bit of a word.
        send(8'hB0);
        lv = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("rst.msb.sequence_out", 32'(seq_m), 32'(0));
        chk("rst.msb.bit_valid",    32'(bv_m),  32'(0));
        chk("rst.msb.load_ready",   32'(ifm.load_ready), 32'(0));
        chk("rst.lsb.sequence_out", 32'(seq_l), 32'(0));
        chk("rst.lsb.word_done",    32'(wd_l),  32'(0));
        chk("rst.lsb.busy",         32'(busy_l), 32'(0));
        q_m.delete();
        q_l.delete();
        @(posedge clock);
        #1 reset = 1'b1;
        send(8'h0D);
        idle(10);

        for (int k = 0; k < 300; k++) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            if (gap > 0) idle(gap);
            send(W'($urandom));
        end
        idle(12);

        chk("drain.msb", 32'(q_m.size()), 32'(0));
        chk("drain.lsb", 32'(q_l.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule : tb_bit_serializer
